// File: rtl/e3bcd_pkg.sv
// Shared constants and types for the excess-3 to BCD sequencing controller.
package e3bcd_pkg;

  // State encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CONV = S_CONV,
    ST_DONE = S_DONE
  } e3bcd_state_t;

  // Excess-3 code range and offset
  localparam logic [3:0] E3_OFFSET = 4'd3;
  localparam logic [3:0] E3_MIN    = 4'b0011;
  localparam logic [3:0] E3_MAX    = 4'b1100;

  // Digit value written for codes outside the excess-3 range
  localparam logic [3:0] BCD_INVALID_FILL = 4'b0000;

endpackage : e3bcd_pkg

// File: rtl/excess3_digit_dec.sv
// Combinational single-digit excess-3 to BCD decoder.
// Codes 0011..1100 decode to code-3; all other codes give the fill value
// and raise o_invalid.
module excess3_digit_dec
  import e3bcd_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [3:0] o_bcd,
  output logic       o_invalid
);

  // Range check and offset removal for one digit
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_invalid = 1'b0;
    o_bcd     = BCD_INVALID_FILL;
    if ((i_code < E3_MIN) || (i_code > E3_MAX)) begin
      o_invalid = 1'b1;
    end else begin
      o_bcd = i_code - E3_OFFSET;
    end
  end

endmodule : excess3_digit_dec

// File: rtl/excess3_bcd_seq_ctrl.sv
// Sequencing controller: converts a packed NDIG-digit excess-3 word into
// packed BCD, one digit per cycle LSB first, through a single shared digit
// decoder. Valid/ready on both sides; invalid digits are flagged per digit.
//
// Optional build macro E3BCD_ERR_ABORT_EN: when defined, conversion stops
// at the first invalid digit; higher digits stay 0 with mask bits clear.
module excess3_bcd_seq_ctrl
  import e3bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_data,
  output logic              out_err,
  output logic [NDIG-1:0]   out_err_mask,
  output logic              busy
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  e3bcd_state_t      r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [4*NDIG-1:0] r_shift;
  logic [4*NDIG-1:0] r_out_data;
  logic [NDIG-1:0]   r_err_mask;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic [3:0]        w_digit;
  logic [3:0]        w_bcd;
  logic              w_invalid;
  logic              w_last;
  logic              w_stop;

  // Current digit under conversion, selected by the digit index
  assign w_digit = r_shift[{r_idx, 2'b00} +: 4];
  assign w_last  = (r_idx == LAST_IDX);

`ifdef E3BCD_ERR_ABORT_EN
  assign w_stop = w_last || w_invalid;
`else
  assign w_stop = w_last;
`endif

  excess3_digit_dec u_dec (
    .i_code    (w_digit),
    .o_bcd     (w_bcd),
    .o_invalid (w_invalid)
  );

  // Control FSM with registered handshake/status outputs and result storage
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the captured word and result registers are reset too, so a reset
    // mid-operation leaves nothing stale to be presented later.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_shift     <= '0;
      r_out_data  <= '0;
      r_err_mask  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every update in
      // this block sees the pre-edge values.
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_shift    <= in_data;
            r_out_data <= '0;
            r_err_mask <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_out_data[{r_idx, 2'b00} +: 4] <= w_bcd;
          if (w_invalid) begin
            r_err_mask[r_idx] <= 1'b1;
          end
          if (w_stop) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign busy         = r_busy;
  assign out_data     = r_out_data;
  assign out_err_mask = r_err_mask;
  assign out_err      = |r_err_mask;

endmodule : excess3_bcd_seq_ctrl

// File: tb/tb_excess3_bcd_seq_ctrl.sv
// Self-checking bench for excess3_bcd_seq_ctrl (NDIG=4). Directed vectors,
// multi-cycle corner sequences, a per-position code sweep and random words
// checked against an arithmetic reference model. Follows E3BCD_ERR_ABORT_EN.
module tb_excess3_bcd_seq_ctrl;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_err;
  logic [NDIG-1:0] out_err_mask;
  logic            busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  excess3_bcd_seq_ctrl #(.NDIG(NDIG)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err),
    .out_err_mask (out_err_mask),
    .busy         (busy)
  );

  typedef struct {
    logic [W-1:0]    din;
    logic [W-1:0]    exp_data;
    logic [NDIG-1:0] exp_mask;
    int              exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: digits are decimal value+3; anything outside 3..12 is an error.
  function automatic void model(input logic [W-1:0] w, output logic [W-1:0] d,
                                output logic [NDIG-1:0] m, output int lat);
    int code;
    d   = '0;
    m   = '0;
    lat = NDIG;
    for (int i = 0; i < NDIG; i++) begin
      code = int'((w >> (4 * i)) & 16'hF);
      if (code >= 3 && code <= 12) begin
        d = d | (W'(code - 3) << (4 * i));
      end else begin
        m[i] = 1'b1;
`ifdef E3BCD_ERR_ABORT_EN
        lat = i + 1;
        break;
`endif
      end
    end
  endfunction

  // Drive one word, measure latency, check result, then complete handshake.
  task automatic run_word(input string name, input logic [W-1:0] din,
                          input logic [W-1:0] exp_d, input logic [NDIG-1:0] exp_m,
                          input int exp_lat);
    int lat;
    @(negedge clk);
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    in_data  = din;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " data"}, 32'(out_data), 32'(exp_d));
    check({name, " mask"}, 32'(out_err_mask), 32'(exp_m));
    check({name, " err"}, 32'(out_err), 32'(exp_m != '0));
    check({name, " busy/ready"}, {30'd0, busy, in_ready}, 32'b10);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " idle after hs"}, {29'd0, out_valid, busy, in_ready}, 32'b001);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0]    md;
    logic [NDIG-1:0] mm;
    int              ml;
    logic [W-1:0]    w;
    logic [W-1:0]    held;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Hand-derived vectors
    vecs.push_back('{16'h4C73, 16'h1940, 4'b0000, 4});
    vecs.push_back('{16'h3333, 16'h0000, 4'b0000, 4});
    vecs.push_back('{16'h9C63, 16'h6930, 4'b0000, 4});
    vecs.push_back('{16'h5A84, 16'h2751, 4'b0000, 4});
`ifdef E3BCD_ERR_ABORT_EN
    vecs.push_back('{16'h4D73, 16'h0040, 4'b0100, 3});
    vecs.push_back('{16'hFFF0, 16'h0000, 4'b0001, 1});
    vecs.push_back('{16'h2221, 16'h0000, 4'b0001, 1});
    vecs.push_back('{16'hD333, 16'h0000, 4'b1000, 4});
`else
    vecs.push_back('{16'h4D73, 16'h1040, 4'b0100, 4});
    vecs.push_back('{16'hFFF0, 16'h0000, 4'b1111, 4});
    vecs.push_back('{16'h2221, 16'h0000, 4'b1111, 4});
    vecs.push_back('{16'hD333, 16'h0000, 4'b1000, 4});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset outputs", {24'd0, in_ready, out_valid, busy, out_err, out_err_mask},
          32'b1000_0000);
    check("reset data", 32'(out_data), 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_word($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp_data,
               vecs[i].exp_mask, vecs[i].exp_lat);

    // Backpressure: hold result, ignore a new in_valid, then release
    @(negedge clk);
    in_data  = 16'h4C73;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ml = 0;
    while (!out_valid && ml < 40) begin
      @(negedge clk);
      ml++;
    end
    check("bp reach done", 32'(out_valid), 32'd1);
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      in_data  = 16'h5555;
      in_valid = (c == 2);
      @(negedge clk);
      check("bp stable", {out_valid, in_ready, out_data}, {1'b1, 1'b0, 16'h1940});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release", {29'd0, out_valid, busy, in_ready}, 32'b001);
    @(negedge clk);
    check("bp no 2nd word", {30'd0, busy, in_ready}, 32'b01);
    check("bp held", 32'(held), 32'h1940);

    // Reset during CONV at idx 2
    in_data  = 16'h4C73;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid reset outputs", {24'd0, in_ready, out_valid, busy, out_err, out_err_mask},
          32'b1000_0000);
    check("mid reset data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NDIG + 2; c++) begin
      @(negedge clk);
      check("post reset quiet", {30'd0, out_valid, busy}, 32'd0);
    end
    run_word("after reset", 16'h3333, 16'h0000, 4'b0000, 4);

    // Every code at every digit position, other digits random
    for (int p = 0; p < NDIG; p++) begin
      for (int code = 0; code < 16; code++) begin
        w = W'($urandom);
        w[4*p +: 4] = 4'(code);
        model(w, md, mm, ml);
        run_word($sformatf("sweep p%0d c%0d", p, code), w, md, mm, ml);
      end
    end

    // Random words
    for (int n = 0; n < 150; n++) begin
      w = W'($urandom);
      model(w, md, mm, ml);
      run_word($sformatf("rand%0d %h", n, w), w, md, mm, ml);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_excess3_bcd_seq_ctrl
